// File: rtl/median_pkg.sv
// Shared types and constants for the serial median window feeder.
package median_pkg;

   typedef enum logic [1:0] {
      ACCEPT,
      EMIT,
      WAIT
   } feeder_state_t;

   localparam int unsigned WIN_SIZE = 9;
   localparam int unsigned WIN_DIM  = 3;

endpackage

// File: rtl/median_window_feeder_if.sv
// Pixel-source and median-link signals of the window feeder.
interface median_window_feeder_if #(
   parameter int unsigned W = 8
);
   logic [W-1:0] PIX_I;
   logic         PIX_VAL;
   logic         PIX_RDY;
   logic         FRM_START;
   logic [W-1:0] DO;
   logic         DSO;
   logic         MED_DONE;
   logic         BUSY;

   // master: pixel source plus median result side; slave: the feeder
   modport master (
      output PIX_I, PIX_VAL, FRM_START, MED_DONE,
      input  PIX_RDY, DO, DSO, BUSY
   );

   modport slave (
      input  PIX_I, PIX_VAL, FRM_START, MED_DONE,
      output PIX_RDY, DO, DSO, BUSY
   );
endinterface

// File: rtl/median_line_buf.sv
// One image line of pixels: combinational read, synchronous write at the same column.
module median_line_buf #(
   parameter int unsigned W     = 8,
   parameter int unsigned IMG_W = 64
) (
   input  logic                     clk_i,
   input  logic                     we_i,
   input  logic [$clog2(IMG_W)-1:0] addr_i,
   input  logic [W-1:0]             wdata_i,
   output logic [W-1:0]             rdata_o
);

   logic [W-1:0] mem_q [IMG_W];

   always_ff @(posedge clk_i) begin
      if (we_i) begin
         mem_q[addr_i] <= wdata_i;
      end
   end

   assign rdata_o = mem_q[addr_i];

endmodule

// File: rtl/median_window_feeder.sv
// Builds a 3x3 window from a raster stream and bursts it serially to the median operator.
module median_window_feeder
   import median_pkg::*;
#(
   parameter int unsigned W     = 8,
   parameter int unsigned IMG_W = 64,
   parameter int unsigned IMG_H = 64
) (
   input  logic                 CLK,
   input  logic                 nRST,
   median_window_feeder_if.slave bus
);

   localparam int unsigned CW = $clog2(IMG_W);
   localparam int unsigned RW = $clog2(IMG_H);

   feeder_state_t state_q, state_d;
   logic [CW-1:0] col_q, col_d, cur_col;
   logic [RW-1:0] row_q, row_d, cur_row;
   logic [3:0]    k_q, k_d;
   logic [W-1:0]  do_q, do_d;
   logic          dso_q, dso_d;
   logic          busy_q, busy_d;
   logic [W-1:0]  win_q [WIN_SIZE];
   logic [W-1:0]  win_d [WIN_SIZE];
   logic          accept, win_valid;
   logic [W-1:0]  top_rd, mid_rd;

   assign accept    = (state_q == ACCEPT) && bus.PIX_VAL;
   assign cur_col   = bus.FRM_START ? '0 : col_q;
   assign cur_row   = bus.FRM_START ? '0 : row_q;
   assign win_valid = (cur_row >= RW'(2)) && (cur_col >= CW'(2));

   median_line_buf #(
      .W     (W),
      .IMG_W (IMG_W)
   ) u_lb_top (
      .clk_i   (CLK),
      .we_i    (accept),
      .addr_i  (cur_col),
      .wdata_i (mid_rd),
      .rdata_o (top_rd)
   );

   median_line_buf #(
      .W     (W),
      .IMG_W (IMG_W)
   ) u_lb_mid (
      .clk_i   (CLK),
      .we_i    (accept),
      .addr_i  (cur_col),
      .wdata_i (bus.PIX_I),
      .rdata_o (mid_rd)
   );

   always_comb begin
      state_d = state_q;
      col_d   = col_q;
      row_d   = row_q;
      k_d     = k_q;
      do_d    = do_q;
      dso_d   = 1'b0;
      busy_d  = busy_q;
      win_d   = win_q;
      unique case (state_q)
         ACCEPT: begin
            if (accept) begin
               // Window stored row-major; shift left, new column enters at the right.
               win_d[0] = win_q[1];
               win_d[1] = win_q[2];
               win_d[2] = top_rd;
               win_d[3] = win_q[4];
               win_d[4] = win_q[5];
               win_d[5] = mid_rd;
               win_d[6] = win_q[7];
               win_d[7] = win_q[8];
               win_d[8] = bus.PIX_I;
               if (cur_col == CW'(IMG_W - 1)) begin
                  col_d = '0;
                  row_d = (cur_row == RW'(IMG_H - 1)) ? '0 : cur_row + 1'b1;
               end else begin
                  col_d = cur_col + 1'b1;
                  row_d = cur_row;
               end
               if (win_valid) begin
                  // First burst pixel is the top-left of the window after the shift.
                  state_d = EMIT;
                  do_d    = win_q[1];
                  dso_d   = 1'b1;
                  k_d     = 4'd1;
                  busy_d  = 1'b1;
               end
            end
         end
         EMIT: begin
            if (k_q < 4'(WIN_SIZE)) begin
               do_d  = win_q[k_q];
               dso_d = 1'b1;
               k_d   = k_q + 4'd1;
            end else begin
               state_d = WAIT;
               k_d     = '0;
            end
         end
         WAIT: begin
            if (bus.MED_DONE) begin
               state_d = ACCEPT;
               busy_d  = 1'b0;
            end
         end
         default: state_d = ACCEPT;
      endcase
   end

   always_ff @(posedge CLK) begin
      if (!nRST) begin
         state_q <= ACCEPT;
         col_q   <= '0;
         row_q   <= '0;
         k_q     <= '0;
         do_q    <= '0;
         dso_q   <= 1'b0;
         busy_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         col_q   <= col_d;
         row_q   <= row_d;
         k_q     <= k_d;
         do_q    <= do_d;
         dso_q   <= dso_d;
         busy_q  <= busy_d;
      end
   end

   always_ff @(posedge CLK) begin
      win_q <= win_d;
   end

   assign bus.PIX_RDY = (state_q == ACCEPT);
   assign bus.DO      = do_q;
   assign bus.DSO     = dso_q;
   assign bus.BUSY    = busy_q;

endmodule

// File: doc/median_window_feeder.md
Name: median_window_feeder

Overview:
Transmit side of the serial median interface. Takes a raster pixel stream and keeps two line buffers plus a 3x3 window. For every interior pixel position it emits the 9 neighbourhood pixels serially on DO/DSO, in the form the median operator expects on its DI/DSI inputs. It then waits for the median's result strobe before accepting more pixels. It sits between the pixel source and the median block.

Parameters:
W, 8, pixel width in bits
IMG_W, 64, image width in pixels (>=3)
IMG_H, 64, image height in lines (>=3)

Ports:
CLK  in  1  clock
nRST  in  1  reset; synchronous, active-low
PIX_I  in  W  input pixel
PIX_VAL  in  1  PIX_I valid
PIX_RDY  out  1  feeder accepts a pixel this cycle
FRM_START  in  1  qualifies PIX_I as pixel (0,0) of a frame
DO  out  W  serial window pixel, driven to the median's DI
DSO  out  1  DO valid, driven to the median's DSI; high for exactly 9 consecutive cycles per window
MED_DONE  in  1  median result strobe, taken from the median's DSO
BUSY  out  1  high in EMIT or WAIT

Behaviour:
- Reset: one clock; nRST is sampled on the CLK edge; reset is synchronous and active-low. While nRST=0 at a CLK edge:
  - state <= ACCEPT; col, row, burst index k <= 0
  - DO <= 0, DSO <= 0, BUSY <= 0
  - Line-buffer contents are not reset.
  - Reset mid-burst aborts the burst; the next cycle shows DSO=0.
- Pixel accept: occurs when state=ACCEPT and PIX_VAL=1. PIX_RDY = (state==ACCEPT), combinational from state.
- Position of the accepted pixel:
  - If FRM_START=1, the pixel is (0,0).
  - Otherwise it is (row,col).
  - The next position is col+1. When col wraps from IMG_W-1 to 0, row increments; row wraps from IMG_H-1 to 0.
  - FRM_START in any other state is ignored.
- Data path on accept at column c:
  - New window column = {top=LB_TOP[c], mid=LB_MID[c], bot=PIX_I}, using old buffer values.
  - The window shifts left by one column; the new column enters on the right.
  - LB_TOP[c] <= LB_MID[c]; LB_MID[c] <= PIX_I.
  - Line buffers use combinational read and synchronous write, one entry per column.
- Window validity: the window is valid when the accepted position has row>=2 and col>=2. A valid window moves state to EMIT; otherwise the state stays ACCEPT.
- EMIT state:
  - k = 0..8, one pixel per cycle. DSO=1 for all 9 cycles.
  - DO order is row-major: top-left, top-mid, top-right, mid-left, ..., bottom-right. Equivalently, positions (r-2,c-2) through (r,c).
  - DO and DSO are registered. If the pixel is accepted in cycle t, DSO=1 in cycles t+1..t+9.
  - After k=8 the state moves to WAIT. DSO=0 outside EMIT; DO holds its last value.
- WAIT state:
  - Remains until MED_DONE=1, then moves to ACCEPT. PIX_RDY=1 from the next cycle.
  - There is no timeout.
- MED_DONE while in ACCEPT or EMIT is ignored and is not remembered.
- Windows per frame: (IMG_W-2)*(IMG_H-2). Border pixels produce no burst.
- Counter widths: $clog2(IMG_W), $clog2(IMG_H), 4 bits for k. Counters wrap exactly at IMG_W-1 and IMG_H-1; there are no power-of-two assumptions.

Decomposition:
- Shared package median_pkg holds:
  - feeder_state_t enum {ACCEPT, EMIT, WAIT}
  - constant WIN_SIZE=9
  - constant WIN_DIM=3
- One sub-module, median_line_buf. It is parameterised by W and IMG_W and has a single write/read port at column c. It is instantiated twice: LB_TOP and LB_MID.

Test Plan:
1. IMG_W=4, IMG_H=4, pixel=16*row+col, PIX_VAL held high, MED_DONE pulsed 3 cycles after each burst ends.
   - After pixel (2,2): DO = 00,01,02,10,11,12,20,21,22 with DSO high for 9 cycles.
   - Exactly 4 bursts per frame. The last burst is 11,12,13,21,22,23,31,32,33.
2. Back-pressure with the same stream:
   - PIX_RDY=0 from the cycle after pixel (2,2) is accepted until the cycle after MED_DONE.
   - No pixel is lost or duplicated; the next burst starts on (2,3).
3. MED_DONE pulsed during EMIT (k=4) and during ACCEPT: both are ignored. The state stays WAIT after the burst until a real MED_DONE.
4. nRST=0 for one cycle at k=5 of a burst:
   - Next cycle DSO=0, PIX_RDY=1, row=col=0.
   - Re-sent frame reproduces the case-1 output exactly.
5. FRM_START asserted on the pixel at position (1,3):
   - Counters resync to (0,0).
   - No burst until the new row 2, col 2. The window contains only new-frame data.
6. PIX_VAL toggled randomly (50%) over 2 frames of a 6x5 image: 12 bursts per frame, each matching the reference-model window order.
